hk_spi_passthru_mux: RTL and testbench

Synthesizable housekeeping-SPI pass-thru router, the multi-channel successor to the fixed mgmt/user flash pass-thru. It oversamples the external housekeeping SPI (sck/csb/sdi) in the core clock domain and decodes the first command byte. On a pass-thru command it routes the rest of the transaction to one of N_CH downstream SPI flash ports. Other command bytes go to the housekeeping register engine via cmd_byte/cmd_valid.

---
 rtl/hk_pt_pkg.sv | 21 ++
 rtl/hk_pt_sync.sv | 39 +++
 rtl/hk_spi_passthru_mux.sv | 211 +++++++++++++++++++++
 tb/tb_hk_spi_passthru_mux.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hk_pt_pkg.sv
// Shared state encoding, command defaults and sizing helper for the
// housekeeping SPI pass-thru router.
package hk_pt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_PASS   = 3'd2;
  localparam state_t ST_IGNORE = 3'd3;
  localparam state_t ST_ABORT  = 3'd4;

  localparam logic [7:0] CMD_BASE_DEF = 8'hC2;
  localparam int         CMD_STEP_DEF = 2;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hk_pt_sync.sv
// Multi-stage synchronizer for an asynchronous SPI pin, followed by one
// edge-detect register so level and edge pulses stay cycle-aligned.
module hk_pt_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              q_r;
  logic              rise_r;
  logic              fall_r;

  // synchronizer chain plus edge register; q and the edge pulses change together
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_r <= {STAGES{RST_VAL}};
      q_r    <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      q_r    <= sync_r[STAGES-1];
      rise_r <= sync_r[STAGES-1] & ~q_r;
      fall_r <= ~sync_r[STAGES-1] & q_r;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/hk_spi_passthru_mux.sv
// Housekeeping SPI router: decodes the first command byte and either routes
// the transaction to one of N_CH flash ports or hands the byte to the register engine.
module hk_spi_passthru_mux
  import hk_pt_pkg::*;
#(
  parameter int              N_CH        = 2,
  parameter logic [7:0]      CMD_BASE    = CMD_BASE_DEF,
  parameter int              CMD_STEP    = CMD_STEP_DEF,
  parameter logic [N_CH-1:0] RESET_MASK  = N_CH'(2'b10),
  parameter int              SYNC_STAGES = 2,
  parameter int              TIMEOUT     = 0,
  localparam int             CW          = ch_width(N_CH)
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic            sck,
  input  logic            csb,
  input  logic            sdi,
  output logic            sdo,
  output logic            sdo_oe,
  output logic [N_CH-1:0] pt_csb,
  output logic [N_CH-1:0] pt_clk,
  output logic [N_CH-1:0] pt_io0,
  input  logic [N_CH-1:0] pt_io1,
  output logic            cpu_reset,
  output logic [7:0]      cmd_byte,
  output logic            cmd_valid,
  output logic            busy,
  output logic [CW-1:0]   active_ch,
  output logic [15:0]     byte_count,
  output logic            abort
);

  logic sck_q_s, sck_rise_s, sck_fall_s;
  logic csb_lvl_unused_s, csb_rise_s, csb_fall_s;
  logic sdi_q_s, sdi_rise_unused_s, sdi_fall_unused_s;

  hk_pt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clock(clock), .resetb(resetb), .d(sck),
    .q(sck_q_s), .rise(sck_rise_s), .fall(sck_fall_s));

  hk_pt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clock(clock), .resetb(resetb), .d(csb),
    .q(csb_lvl_unused_s), .rise(csb_rise_s), .fall(csb_fall_s));

  hk_pt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clock(clock), .resetb(resetb), .d(sdi),
    .q(sdi_q_s), .rise(sdi_rise_unused_s), .fall(sdi_fall_unused_s));

  state_t          state_r;
  logic [2:0]      bit_cnt_r;
  logic            cmd_full_r;
  logic [7:0]      shift_r;
  logic [CW-1:0]   ch_r;
  logic            armed_r;
  logic [2:0]      edge_cnt_r;
  logic [15:0]     tmo_r;
  logic [N_CH-1:0] pt_csb_r, pt_clk_r, pt_io0_r;
  logic            sdo_r, sdo_oe_r, cpu_reset_r, cmd_valid_r, busy_r, abort_r;
  logic [7:0]      cmd_byte_r;
  logic [15:0]     byte_count_r;

  logic            hit_s;
  logic [CW-1:0]   hit_ch_s;
  logic            sck_edge_s;
  logic            tmo_hit_s;

  // match the captured byte against every channel's pass-thru command
  always_comb begin
    hit_s    = 1'b0;
    hit_ch_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit_ch_s = (shift_r == 8'(int'(CMD_BASE) + k * CMD_STEP)) ? CW'(k) : hit_ch_s;
      hit_s    = hit_s | (shift_r == 8'(int'(CMD_BASE) + k * CMD_STEP));
    end
  end

  // tmo_r counts clocks since the last synced sck edge; abort fires as it reaches TIMEOUT
  always_comb begin
    sck_edge_s = sck_rise_s | sck_fall_s;
    tmo_hit_s  = (TIMEOUT != 0) && !sck_edge_s && (tmo_r == 16'(TIMEOUT - 1));
  end

  // transaction sequencing and every registered output
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      cmd_full_r   <= 1'b0;
      shift_r      <= 8'h00;
      ch_r         <= '0;
      armed_r      <= 1'b0;
      edge_cnt_r   <= 3'd0;
      tmo_r        <= 16'd0;
      pt_csb_r     <= '1;
      pt_clk_r     <= '0;
      pt_io0_r     <= '0;
      sdo_r        <= 1'b0;
      sdo_oe_r     <= 1'b0;
      cpu_reset_r  <= 1'b0;
      cmd_byte_r   <= 8'h00;
      cmd_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      byte_count_r <= 16'd0;
      abort_r      <= 1'b0;
    end else begin
      cmd_valid_r <= 1'b0;
      abort_r     <= 1'b0;
      tmo_r       <= sck_edge_s ? 16'd1 : tmo_r + 16'd1;
      if (csb_rise_s) begin
        // end of transaction wins over any sck edge in the same cycle
        state_r     <= ST_IDLE;
        busy_r      <= 1'b0;
        armed_r     <= 1'b0;
        pt_csb_r    <= '1;
        pt_clk_r    <= '0;
        pt_io0_r    <= '0;
        sdo_r       <= 1'b0;
        sdo_oe_r    <= 1'b0;
        cpu_reset_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            tmo_r <= 16'd0;
            if (csb_fall_s) begin
              state_r      <= ST_CMD;
              busy_r       <= 1'b1;
              bit_cnt_r    <= 3'd0;
              cmd_full_r   <= 1'b0;
              byte_count_r <= 16'd0;
            end
          end
          ST_CMD: begin
            if (tmo_hit_s) begin
              state_r  <= ST_ABORT;
              abort_r  <= 1'b1;
              pt_csb_r <= '1;
            end else if (cmd_full_r) begin
              cmd_full_r <= 1'b0;
              if (hit_s) begin
                state_r     <= ST_PASS;
                ch_r        <= hit_ch_s;
                armed_r     <= 1'b0;
                edge_cnt_r  <= 3'd0;
                pt_csb_r    <= ~(N_CH'(1) << hit_ch_s);
                cpu_reset_r <= RESET_MASK[hit_ch_s];
                sdo_oe_r    <= 1'b1;
              end else begin
                state_r     <= ST_IGNORE;
                cmd_valid_r <= 1'b1;
                cmd_byte_r  <= shift_r;
              end
            end else if (sck_rise_s) begin
              shift_r    <= {shift_r[6:0], sdi_q_s};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              cmd_full_r <= (bit_cnt_r == 3'd7);
            end
          end
          ST_PASS: begin
            if (tmo_hit_s) begin
              state_r     <= ST_ABORT;
              abort_r     <= 1'b1;
              pt_csb_r    <= '1;
              pt_clk_r    <= '0;
              pt_io0_r    <= '0;
              sdo_r       <= 1'b0;
              sdo_oe_r    <= 1'b0;
              cpu_reset_r <= 1'b0;
            end else begin
              // armed_r masks the tail of command bit 0, still high on entry
              if (sck_fall_s) armed_r <= 1'b1;
              pt_clk_r <= N_CH'(sck_q_s & armed_r) << ch_r;
              pt_io0_r <= N_CH'(sdi_q_s) << ch_r;
              sdo_r    <= pt_io1[ch_r];
              if (sck_rise_s && armed_r) begin
                edge_cnt_r <= edge_cnt_r + 3'd1;
                if (edge_cnt_r == 3'd7 && byte_count_r != 16'hFFFF) begin
                  byte_count_r <= byte_count_r + 16'd1;
                end
              end
            end
          end
          ST_IGNORE: begin
            sdo_oe_r <= 1'b0;
          end
          ST_ABORT: begin
            pt_csb_r <= '1;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sdo        = sdo_r;
  assign sdo_oe     = sdo_oe_r;
  assign pt_csb     = pt_csb_r;
  assign pt_clk     = pt_clk_r;
  assign pt_io0     = pt_io0_r;
  assign cpu_reset  = cpu_reset_r;
  assign cmd_byte   = cmd_byte_r;
  assign cmd_valid  = cmd_valid_r;
  assign busy       = busy_r;
  assign active_ch  = ch_r;
  assign byte_count = byte_count_r;
  assign abort      = abort_r;

endmodule

// File: tb/tb_hk_spi_passthru_mux.sv
// Randomized bench for the pass-thru router: SPI master tasks, two flash
// models and a transaction-level expectation model.
module tb_hk_spi_passthru_mux;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        sck = 1'b0;
  logic        csb = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo, sdo_oe, cpu_reset, cmd_valid, busy, abort;
  logic [1:0]  pt_csb, pt_clk, pt_io0, pt_io1;
  logic [7:0]  cmd_byte;
  logic [0:0]  active_ch;
  logic [15:0] byte_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [2][256];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  always #5 clock = ~clock;

  hk_spi_passthru_mux #(
    .N_CH(2), .CMD_BASE(8'hC2), .CMD_STEP(2), .RESET_MASK(2'b10),
    .SYNC_STAGES(2), .TIMEOUT(100)
  ) dut (
    .clock(clock), .resetb(resetb), .sck(sck), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .pt_csb(pt_csb), .pt_clk(pt_clk),
    .pt_io0(pt_io0), .pt_io1(pt_io1), .cpu_reset(cpu_reset),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .busy(busy),
    .active_ch(active_ch), .byte_count(byte_count), .abort(abort)
  );

  // SPI flash model per channel: mode 0, command 03 + 24-bit address, then data
  for (genvar g = 0; g < 2; g++) begin : g_flash
    int          bits = 0;
    logic [31:0] hdr = 32'h0;
    logic        out_r = 1'b0;
    always @(posedge pt_clk[g] or posedge pt_csb[g]) begin
      if (pt_csb[g]) begin
        bits = 0;
        hdr  = 32'h0;
      end else begin
        if (bits < 32) hdr = {hdr[30:0], pt_io0[g]};
        bits = bits + 1;
      end
    end
    always @(negedge pt_clk[g] or posedge pt_csb[g]) begin
      if (pt_csb[g]) out_r = 1'b0;
      else if (bits >= 32 && hdr[31:24] == 8'h03)
        out_r = mem[g][8'(hdr[7:0] + 8'((bits - 32) / 8))][7 - ((bits - 32) % 8)];
    end
    assign pt_io1[g] = out_r;
  end

  // per-transaction observation, restarted whenever epoch changes
  int         epoch = 0;
  int         mon_epoch = 0;
  int         cv_cnt = 0;
  int         oe_cnt = 0;
  int         rise_cnt [2];
  logic [7:0] cv_byte = 8'h00;
  logic [1:0] csb_low_seen = 2'b00;
  logic       rst_seen = 1'b0;
  logic [1:0] clk_prev = 2'b00;

  always @(negedge clock) begin
    if (mon_epoch != epoch) begin
      mon_epoch    = epoch;
      cv_cnt       = 0;
      oe_cnt       = 0;
      rise_cnt[0]  = 0;
      rise_cnt[1]  = 0;
      csb_low_seen = 2'b00;
      rst_seen     = 1'b0;
    end else begin
      if (cmd_valid) begin
        cv_cnt  = cv_cnt + 1;
        cv_byte = cmd_byte;
      end
      if (sdo_oe) oe_cnt = oe_cnt + 1;
      csb_low_seen = csb_low_seen | ~pt_csb;
      rst_seen     = rst_seen | cpu_reset;
      for (int k = 0; k < 2; k++)
        if (pt_clk[k] && !clk_prev[k]) rise_cnt[k] = rise_cnt[k] + 1;
    end
    clk_prev = pt_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // channel selected by a command byte, -1 when it is not a pass-thru command
  function automatic int route_of(input logic [7:0] c);
    for (int k = 0; k < 2; k++)
      if (c == 8'(8'hC2 + 2 * k)) return k;
    return -1;
  endfunction

  task automatic spi_xfer(input int hp);
    logic [7:0] b, r;
    rx_q.delete();
    @(negedge clock);
    csb = 1'b0;
    repeat (8) @(negedge clock);
    foreach (tx_q[i]) begin
      b = tx_q[i];
      r = 8'h00;
      for (int j = 7; j >= 0; j--) begin
        sdi = b[j];
        repeat (hp) @(negedge clock);
        sck  = 1'b1;
        r[j] = sdo;
        repeat (hp) @(negedge clock);
        sck = 1'b0;
      end
      rx_q.push_back(r);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pt_csb"}, 32'(pt_csb), 32'h3);
    check_eq({tag, "_misc"}, 32'({pt_clk, pt_io0, sdo, sdo_oe, cpu_reset, cmd_valid, busy, active_ch, abort}), 32'h0);
    check_eq({tag, "_cmd_byte"}, 32'(cmd_byte), 32'h0);
    check_eq({tag, "_byte_count"}, 32'(byte_count), 32'h0);
  endtask

  task automatic run_case(input logic [7:0] cmd, input logic [23:0] addr, input int nrd, input int hp);
    int k;
    k = route_of(cmd);
    tx_q.delete();
    tx_q.push_back(cmd);
    if (k >= 0) begin
      tx_q.push_back(8'h03);
      tx_q.push_back(addr[23:16]);
      tx_q.push_back(addr[15:8]);
      tx_q.push_back(addr[7:0]);
    end
    for (int i = 0; i < nrd; i++) tx_q.push_back((k >= 0) ? 8'h00 : 8'h03);
    epoch++;
    spi_xfer(hp);
    repeat (hp) @(negedge clock);
    check_eq("busy_mid", 32'(busy), 32'h1);
    check_eq("byte_count", 32'(byte_count), (k >= 0) ? 32'(tx_q.size() - 1) : 32'h0);
    if (k >= 0) begin
      check_eq("active_ch", 32'(active_ch), 32'(k));
      check_eq("cpu_reset_mid", 32'(cpu_reset), 32'(k == 1));
      check_eq("sdo_oe_pass", 32'(sdo_oe), 32'h1);
    end else begin
      check_eq("sdo_oe_ignore", 32'(sdo_oe), 32'h0);
    end
    csb = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_eq("end_pt_csb", 32'(pt_csb), 32'h3);
    check_eq("end_cpu_reset", 32'(cpu_reset), 32'h0);
    check_eq("end_sdo_oe", 32'(sdo_oe), 32'h0);
    check_eq("end_busy", 32'(busy), 32'h0);
    @(negedge clock);
    check_eq("csb_low_seen", 32'(csb_low_seen), (k >= 0) ? 32'(1 << k) : 32'h0);
    check_eq("cpu_reset_seen", 32'(rst_seen), 32'(k == 1));
    check_eq("oe_seen", 32'(oe_cnt > 0), 32'(k >= 0));
    check_eq("cmd_valid_cnt", 32'(cv_cnt), (k < 0) ? 32'h1 : 32'h0);
    if (k < 0) check_eq("cmd_byte", 32'(cv_byte), 32'(cmd));
    for (int j = 0; j < 2; j++)
      check_eq("pt_clk_rises", 32'(rise_cnt[j]), (j == k) ? 32'(8 * (tx_q.size() - 1)) : 32'h0);
    if (k >= 0)
      for (int i = 0; i < nrd; i++)
        check_eq("read_data", 32'(rx_q[5 + i]), 32'(mem[k][8'(addr[7:0] + 8'(i))]));
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int   n;
    logic got;
    logic [7:0] c;
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = 8'($urandom);
    end
    mem[0][0] = 8'h6F; mem[0][1] = 8'h00; mem[0][2] = 8'h00; mem[0][3] = 8'h0B;
    mem[0][4] = 8'h93; mem[0][5] = 8'h01; mem[0][6] = 8'h00; mem[0][7] = 8'h00;

    #12;
    check_reset_vals("por");
    @(negedge clock);
    resetb = 1'b1;
    repeat (4) @(negedge clock);

    run_case(8'h40, 24'h0, 1, 6);
    run_case(8'hC2, 24'h0, 8, 6);
    run_case(8'hC4, 24'h000010, 4, 7);

    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 2))
        0:       c = 8'hC2;
        1:       c = 8'hC4;
        default: c = 8'($urandom);
      endcase
      run_case(c, 24'($urandom), $urandom_range(1, 5), $urandom_range(6, 9));
    end

    // idle sck with csb low after a pass-thru command
    tx_q.delete();
    tx_q.push_back(8'hC2);
    spi_xfer(7);
    n   = 0;
    got = 1'b0;
    while (n < 130 && !got) begin
      @(posedge clock);
      #1;
      n++;
      got = abort;
    end
    check_eq("abort_seen", 32'(got), 32'h1);
    check_eq("abort_latency_in_window", 32'(n >= 101 && n <= 103), 32'h1);
    check_eq("abort_pt_csb", 32'(pt_csb), 32'h3);
    @(posedge clock);
    #1;
    check_eq("abort_one_cycle", 32'(abort), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'h1);
    epoch++;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      sdi = 1'($urandom);
      sck = 1'b1;
      repeat (7) @(negedge clock);
      sck = 1'b0;
      repeat (7) @(negedge clock);
    end
    check_eq("post_abort_clk", 32'(rise_cnt[0] + rise_cnt[1]), 32'h0);
    check_eq("post_abort_csb", 32'(csb_low_seen), 32'h0);
    csb = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_eq("abort_to_idle", 32'(busy), 32'h0);
    repeat (4) @(negedge clock);

    // asynchronous reset in the middle of a routed read
    tx_q.delete();
    tx_q.push_back(8'hC2);
    tx_q.push_back(8'h03);
    spi_xfer(7);
    repeat (3) @(negedge clock);
    check_eq("pre_reset_pt_csb", 32'(pt_csb), 32'h2);
    #2;
    resetb = 1'b0;
    #1;
    check_reset_vals("mid_pass_reset");
    csb = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    repeat (4) @(negedge clock);
    run_case(8'hC2, 24'h000002, 4, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
